// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue: holds fetch predictions, checks them against
// execute outcomes, emits branch lookup table updates and misprediction redirects.
module branch_resolve_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_WIDTH  = 32,
    parameter int PC_INC     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_push_pc,
    input  logic                  i_push_pred_taken,
    input  logic [ADDR_WIDTH-1:0] i_push_pred_target,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    input  logic                  i_resolve,
    input  logic                  i_resolve_taken,
    input  logic [ADDR_WIDTH-1:0] i_resolve_target,
    output logic                  o_blt_write,
    output logic [ADDR_WIDTH-1:0] o_blt_write_key,
    output logic [ADDR_WIDTH-1:0] o_blt_write_val,
    output logic                  o_blt_hit,
    output logic                  o_mispredict,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic [CNT_WIDTH-1:0]  o_resolve_cnt,
    output logic [CNT_WIDTH-1:0]  o_mispredict_cnt
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic                  pred_taken;
        logic [ADDR_WIDTH-1:0] pred_target;
    } entry_t;

    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    entry_t                r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd, r_wr;
    logic [DEPTH_LOG2:0]   r_count;

    logic                  r_blt_write, r_blt_hit, r_mispredict;
    logic [ADDR_WIDTH-1:0] r_blt_key, r_blt_val, r_redirect_pc;
    logic                  r_overflow, r_underflow;
    logic [CNT_WIDTH-1:0]  r_resolve_cnt, r_mispredict_cnt;

    entry_t                w_head;
    logic                  w_full, w_empty, w_pop, w_mis, w_push_ok;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd];
    assign w_pop   = i_resolve & ~w_empty;
    assign w_mis   = w_pop & ((w_head.pred_taken != i_resolve_taken) |
                              (i_resolve_taken & (w_head.pred_target != i_resolve_target)));
    // A pop in the same cycle frees the slot, so a full queue still accepts the push;
    // a mispredict makes any same-cycle push wrong-path.
    assign w_push_ok = i_push & ~w_mis & (~w_full | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_mis)
            w_count_nxt = '0;
        else if (w_push_ok & ~w_pop)
            w_count_nxt = r_count + (DEPTH_LOG2+1)'(1);
        else if (~w_push_ok & w_pop)
            w_count_nxt = r_count - (DEPTH_LOG2+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push_ok & ~reset)
            r_mem[r_wr] <= '{pc: i_push_pc, pred_taken: i_push_pred_taken,
                             pred_target: i_push_pred_target};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push_ok)
                r_wr <= r_wr + DEPTH_LOG2'(1);
            if (w_mis)
                r_rd <= r_wr;
            else if (w_pop)
                r_rd <= r_rd + DEPTH_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blt_write      <= 1'b0;
            r_blt_key        <= '0;
            r_blt_val        <= '0;
            r_blt_hit        <= 1'b0;
            r_mispredict     <= 1'b0;
            r_redirect_pc    <= '0;
            r_overflow       <= 1'b0;
            r_underflow      <= 1'b0;
            r_resolve_cnt    <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_blt_write  <= w_pop;
            r_mispredict <= w_mis;
            if (w_pop) begin
                r_blt_key     <= w_head.pc;
                r_blt_val     <= i_resolve_target;
                r_blt_hit     <= i_resolve_taken;
                r_redirect_pc <= i_resolve_taken ? i_resolve_target
                                                 : w_head.pc + ADDR_WIDTH'(PC_INC);
                if (r_resolve_cnt != '1)
                    r_resolve_cnt <= r_resolve_cnt + CNT_WIDTH'(1);
            end
            if (w_mis && r_mispredict_cnt != '1)
                r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
            if (i_push & w_full & ~w_pop)
                r_overflow <= 1'b1;
            if (i_resolve & w_empty)
                r_underflow <= 1'b1;
        end
    end

    assign o_full           = w_full;
    assign o_empty          = w_empty;
    assign o_count          = r_count;
    assign o_blt_write      = r_blt_write;
    assign o_blt_write_key  = r_blt_key;
    assign o_blt_write_val  = r_blt_val;
    assign o_blt_hit        = r_blt_hit;
    assign o_mispredict     = r_mispredict;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_overflow       = r_overflow;
    assign o_underflow      = r_underflow;
    assign o_resolve_cnt    = r_resolve_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed and randomized checks of branch_resolve_queue against a queue-based model.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_push, i_push_pred_taken, i_resolve, i_resolve_taken;
    logic [31:0] i_push_pc, i_push_pred_target, i_resolve_target;
    logic        o_full, o_empty, o_blt_write, o_blt_hit, o_mispredict, o_overflow, o_underflow;
    logic [3:0]  o_count;
    logic [31:0] o_blt_write_key, o_blt_write_val, o_redirect_pc, o_resolve_cnt, o_mispredict_cnt;

    always #5 clk = ~clk;

    branch_resolve_queue dut (
        .clk(clk), .reset(reset),
        .i_push(i_push), .i_push_pc(i_push_pc), .i_push_pred_taken(i_push_pred_taken),
        .i_push_pred_target(i_push_pred_target),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
        .i_resolve(i_resolve), .i_resolve_taken(i_resolve_taken), .i_resolve_target(i_resolve_target),
        .o_blt_write(o_blt_write), .o_blt_write_key(o_blt_write_key), .o_blt_write_val(o_blt_write_val),
        .o_blt_hit(o_blt_hit), .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
        .o_overflow(o_overflow), .o_underflow(o_underflow),
        .o_resolve_cnt(o_resolve_cnt), .o_mispredict_cnt(o_mispredict_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    logic        m_write, m_hit, m_mis, m_ovf, m_unf;
    logic [31:0] m_key, m_val, m_redir, m_rcnt, m_mcnt;
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_write = 0; m_hit = 0; m_mis = 0; m_ovf = 0; m_unf = 0;
        m_key = 0; m_val = 0; m_redir = 0; m_rcnt = 0; m_mcnt = 0;
    endtask

    task automatic model_step(input logic rst, input logic p, input logic [31:0] pc, input logic pt,
                              input logic [31:0] ptgt, input logic r, input logic rt,
                              input logic [31:0] rtgt);
        ent_t e;
        bit   acc;
        if (rst) begin
            model_clear();
            return;
        end
        acc     = r && q.size() > 0;
        m_write = acc;
        m_mis   = 0;
        if (acc) begin
            e     = q.pop_front();
            m_mis = (e.pt != rt) || (rt && e.tgt != rtgt);
            m_key = e.pc; m_val = rtgt; m_hit = rt;
            m_redir = rt ? rtgt : e.pc + 32'd1;
            if (m_rcnt != 32'hFFFF_FFFF) m_rcnt++;
            if (m_mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
            if (m_mis) q.delete();
        end
        if (r && !acc) m_unf = 1;
        if (p && !m_mis) begin
            // size here is already post-pop, so a same-cycle pop makes room
            if (q.size() < 8) q.push_back('{pc, pt, ptgt});
            else m_ovf = 1;
        end
    endtask

    task automatic step(input logic rst, input logic p, input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptgt, input logic r, input logic rt,
                        input logic [31:0] rtgt);
        reset = rst; i_push = p; i_push_pc = pc; i_push_pred_taken = pt; i_push_pred_target = ptgt;
        i_resolve = r; i_resolve_taken = rt; i_resolve_target = rtgt;
        model_step(rst, p, pc, pt, ptgt, r, rt, rtgt);
        @(posedge clk);
        #1;
        chk("count", o_count, q.size());
        chk("full", o_full, q.size() == 8);
        chk("empty", o_empty, q.size() == 0);
        chk("blt_write", o_blt_write, m_write);
        chk("mispredict", o_mispredict, m_mis);
        chk("overflow", o_overflow, m_ovf);
        chk("underflow", o_underflow, m_unf);
        chk("resolve_cnt", o_resolve_cnt, m_rcnt);
        chk("mispredict_cnt", o_mispredict_cnt, m_mcnt);
        if (m_write) begin
            chk("blt_key", o_blt_write_key, m_key);
            chk("blt_val", o_blt_write_val, m_val);
            chk("blt_hit", o_blt_hit, m_hit);
        end
        if (m_mis) chk("redirect_pc", o_redirect_pc, m_redir);
    endtask

    task automatic push1(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        step(0, 1, pc, pt, tgt, 0, 0, 0);
    endtask

    task automatic res1(input logic rt, input logic [31:0] tgt);
        step(0, 0, 0, 0, 0, 1, rt, tgt);
    endtask

    initial begin
        logic [31:0] pc, tgt, rtgt;
        logic        pt, rt;
        model_clear();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // not-taken resolve, correct prediction
        push1(32'h10, 0, 32'h0);
        res1(0, 32'h40);
        chk("t1_key", o_blt_write_key, 32'h10);
        chk("t1_val", o_blt_write_val, 32'h40);
        chk("t1_hit", o_blt_hit, 0);

        // taken with wrong target
        push1(32'h20, 1, 32'h80);
        res1(1, 32'h84);
        chk("t2_redir", o_redirect_pc, 32'h84);
        chk("t2_mcnt", o_mispredict_cnt, 1);

        // predicted taken, actually not taken, younger entries flushed
        push1(32'h30, 1, 32'h50);
        push1(32'h31, 0, 32'h0);
        push1(32'h32, 0, 32'h0);
        res1(0, 32'h99);
        chk("t3_redir", o_redirect_pc, 32'h31);
        chk("t3_count", o_count, 0);

        // mispredict with same-cycle push: push dropped, no overflow
        push1(32'h40, 0, 0);
        step(0, 1, 32'h41, 0, 0, 1, 1, 32'h60);

        // fill, push+resolve while full, then overflow
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) push1(32'h100 + i, 0, 0);
        chk("t4_full", o_full, 1);
        step(0, 1, 32'h200, 0, 0, 1, 0, 32'h7);
        chk("t4_count_pr", o_count, 8);
        chk("t4_no_ovf", o_overflow, 0);
        push1(32'h201, 0, 0);
        chk("t4_ovf", o_overflow, 1);

        // resolve on empty, with a same-cycle push accepted
        step(1, 0, 0, 0, 0, 0, 0, 0);
        res1(0, 0);
        chk("t5_unf", o_underflow, 1);
        chk("t5_rcnt", o_resolve_cnt, 0);
        step(0, 1, 32'h77, 0, 0, 1, 0, 0);
        chk("t5_count", o_count, 1);

        // reset wins over a resolve
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) push1(32'h300 + i, 0, 0);
        step(1, 1, 32'h400, 0, 0, 1, 0, 0);
        chk("t6_count", o_count, 0);
        chk("t6_write", o_blt_write, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_write2", o_blt_write, 0);

        // randomized traffic; resolutions biased toward correct predictions
        for (int n = 0; n < 3000; n++) begin
            pc  = $urandom;
            pt  = $urandom_range(0, 1);
            tgt = 32'h1000 + 32'($urandom_range(0, 3));
            if (q.size() > 0 && $urandom_range(0, 99) < 80) begin
                rt   = q[0].pt;
                rtgt = rt ? q[0].tgt : $urandom;
                if ($urandom_range(0, 9) == 0) rtgt = 32'h1000 + 32'($urandom_range(0, 3));
            end else begin
                rt   = $urandom_range(0, 1);
                rtgt = 32'h1000 + 32'($urandom_range(0, 3));
            end
            step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 60, pc, pt, tgt,
                 $urandom_range(0, 99) < 45, rt, rtgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
